// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous RAM between instruction and data ports.
// Data wins contention until the instruction port has waited MAX_WAIT cycles.
module mem_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024,
  parameter int MAX_WAIT   = 4,
  parameter int ADDR_W     = $clog2(MEM_DEPTH)
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  i_req,
  input  logic [31:0]           iaddr,
  output logic                  i_gnt,
  output logic                  i_valid,
  output logic [DATA_WIDTH-1:0] idata,
  input  logic                  d_req,
  input  logic                  d_rw,
  input  logic [31:0]           daddr,
  input  logic [DATA_WIDTH-1:0] ddata_w,
  output logic                  d_gnt,
  output logic                  d_valid,
  output logic [DATA_WIDTH-1:0] ddata_r,
  output logic                  err,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  localparam int SW = $clog2(MAX_WAIT + 1);
  typedef enum logic [1:0] {NONE, INSTR, DATA} owner_e;
  owner_e owner_q, owner_d;
  logic [SW-1:0] starve_q, starve_d;
  logic err_q, err_d, wr_q, wr_d;
  logic i_win, d_win, sel_bad;
  logic [31:0] sel_addr;
  // State updates use the ungated wins; the async reset already holds the flops.
  always_comb begin
    i_win     = i_req && (!d_req || starve_q == SW'(MAX_WAIT));
    d_win     = d_req && !i_win;
    i_gnt     = RESET_N && i_win;
    d_gnt     = RESET_N && d_win;
    sel_addr  = d_win ? daddr : iaddr;
    sel_bad   = (sel_addr[1:0] != 2'b00) || (sel_addr >= 32'(4 * MEM_DEPTH));
    mem_en    = (i_gnt || d_gnt) && !sel_bad;
    mem_we    = mem_en && d_gnt && d_rw;
    mem_addr  = sel_addr[ADDR_W+1:2];
    mem_wdata = ddata_w;
    owner_d   = i_win ? INSTR : d_win ? DATA : NONE;
    err_d     = (i_win || d_win) && sel_bad;
    wr_d      = d_win && d_rw;
    starve_d  = i_win ? '0 : (i_req && starve_q != SW'(MAX_WAIT)) ? starve_q + 1'b1 : starve_q;
  end
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      owner_q  <= NONE;
      starve_q <= '0;
      err_q    <= 1'b0;
      wr_q     <= 1'b0;
    end else begin
      owner_q  <= owner_d;
      starve_q <= starve_d;
      err_q    <= err_d;
      wr_q     <= wr_d;
    end
  end
  assign i_valid = owner_q == INSTR;
  assign d_valid = owner_q == DATA;
  assign err     = err_q;
  assign idata   = (i_valid && !err_q) ? mem_rdata : '0;
  assign ddata_r = (d_valid && !err_q && !wr_q) ? mem_rdata : '0;
endmodule
